// File: rtl/memory_stream_pkg.sv
// Shared types and constants for the signed list streamer.
// FSM encoding, buffer depth and stat accumulator sizing.
package memory_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int BUF_DEPTH = 2;

  // Sum of up to 2**al words of mw bits never overflows.
  function automatic int stat_sum_w(input int mw,
                                    input int al);
    return mw + al + 1;
  endfunction

endpackage

// File: rtl/stream_skid_fifo2.sv
// Two-entry synchronous FIFO with a registered head.
// Absorbs read latency and output backpressure.
module stream_skid_fifo2
  import memory_stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/memory_list_signed_streamer.sv
// Streams base..base+length-1 (wrapping) from a 1-cycle signed memory.
// Optional running min/max/sum under MEMORY_LIST_STREAMER_STATS_EN.
module memory_list_signed_streamer
  import memory_stream_pkg::*;
#(
  parameter int mem_width   = 16,
  parameter int address_len = 10,
  parameter int mem_depth   = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [address_len-1:0]        base_addr,
  input  logic [address_len:0]          length,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_r_en,
  output logic [address_len-1:0]        mem_r_addr,
  input  logic signed [mem_width-1:0]   mem_r_data,
  output logic signed [mem_width-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic signed [mem_width-1:0]   stat_min,
  output logic signed [mem_width-1:0]   stat_max,
  output logic signed
    [stat_sum_w(mem_width, address_len)-1:0] stat_sum
);

  localparam int AW = address_len;
  localparam int LW = address_len + 1;
  localparam int SW = stat_sum_w(mem_width, address_len);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, issued_q, beat_q;
  logic [AW-1:0] addr_q;
  logic          pend_q;

  logic          accept, pop, issue, last_issue, last_pop;
  logic [LW-1:0] len_c;
  logic [1:0]    occ;
  logic [2:0]    inflight;
  logic [mem_width-1:0] head;

  assign accept = (state_q == IDLE) && start;
  assign len_c  = (length > LW'(mem_depth)) ?
                  LW'(mem_depth) : length;

  assign pop      = out_valid && out_ready;
  assign inflight = {1'b0, occ} + {2'b0, pend_q};

  // Credit: words buffered or in flight must fit after this pop.
  assign issue = (state_q == RUN) &&
                 (issued_q != len_q) &&
                 (inflight < 3'(BUF_DEPTH) + {2'b0, pop});

  assign last_issue = issue &&
                      (issued_q == len_q - LW'(1));
  assign out_last   = out_valid &&
                      (beat_q == len_q - LW'(1));
  assign last_pop   = pop && out_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (len_q == '0)     state_d = DONE;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN: if (last_pop) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    mem_r_en = issue;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q    <= '0;
      issued_q <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      pend_q <= issue;
      if (accept) begin
        len_q    <= len_c;
        issued_q <= '0;
        beat_q   <= '0;
        addr_q   <= base_addr;
      end else begin
        if (issue) begin
          issued_q <= issued_q + LW'(1);
          addr_q   <= (addr_q == AW'(mem_depth - 1)) ?
                      '0 : addr_q + AW'(1);
        end
        if (pop) beat_q <= beat_q + LW'(1);
      end
    end
  end

  assign mem_r_addr = addr_q;

  stream_skid_fifo2 #(
    .W(mem_width)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push_i (pend_q),
    .data_i (mem_r_data),
    .pop_i  (pop),
    .head_o (head),
    .valid_o(out_valid),
    .occ_o  (occ)
  );

  assign out_data = head;

`ifdef MEMORY_LIST_STREAMER_STATS_EN
  localparam logic signed [mem_width-1:0] SMAX =
    {1'b0, {(mem_width-1){1'b1}}};
  localparam logic signed [mem_width-1:0] SMIN =
    {1'b1, {(mem_width-1){1'b0}}};

  logic signed [mem_width-1:0] min_q, max_q;
  logic signed [SW-1:0]        sum_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (accept) begin
      min_q <= SMAX;
      max_q <= SMIN;
      sum_q <= '0;
    end else if (pend_q) begin
      if (mem_r_data < min_q) min_q <= mem_r_data;
      if (mem_r_data > max_q) max_q <= mem_r_data;
      sum_q <= sum_q + SW'(mem_r_data);
    end
  end

  assign stat_min = min_q;
  assign stat_max = max_q;
  assign stat_sum = sum_q;
`else
  assign stat_min = '0;
  assign stat_max = '0;
  assign stat_sum = '0;
`endif

endmodule

// File: tb/tb_memory_list_signed_streamer.sv
// Directed and randomized bench for memory_list_signed_streamer.
// Memory preloaded with mem[i] = i - 512.
module tb_memory_list_signed_streamer;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic [9:0]         base_addr = '0;
  logic [10:0]        length = '0;
  logic               busy, done, mem_r_en;
  logic [9:0]         mem_r_addr;
  logic signed [15:0] mem_r_data = '0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out_last;
  logic signed [15:0] stat_min, stat_max;
  logic signed [26:0] stat_sum;

  logic signed [15:0] mem [1024];

  int checks = 0;
  int failures = 0;

  memory_list_signed_streamer dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_r_en  (mem_r_en),
    .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .stat_min  (stat_min),
    .stat_max  (stat_max),
    .stat_sum  (stat_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic int word_at(input int a);
    return (a % 1024) - 512;
  endfunction

  task automatic chk_stats(input int base, input int n);
    longint smin, smax, ssum;
    smin = 32767;
    smax = -32768;
    ssum = 0;
    for (int i = 0; i < n; i++) begin
      if (word_at(base + i) < smin) smin = word_at(base + i);
      if (word_at(base + i) > smax) smax = word_at(base + i);
      ssum += word_at(base + i);
    end
`ifndef MEMORY_LIST_STREAMER_STATS_EN
    smin = 0;
    smax = 0;
    ssum = 0;
`endif
    chk("stat_min", stat_min, smin);
    chk("stat_max", stat_max, smax);
    chk("stat_sum", stat_sum, ssum);
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0 repeating, 2 random
  task automatic run_job(input int base, input int len,
                         input int rmode, input bit mid,
                         input bit timing);
    int n, issued, popped, first_en, first_val;
    int done_c, last_pop_c, budget;
    bit held;
    logic signed [15:0] held_d;
    n = (len > 1024) ? 1024 : len;
    issued = 0;
    popped = 0;
    first_en = -1;
    first_val = -1;
    done_c = -1;
    last_pop_c = -1;
    held = 1'b0;
    held_d = '0;
    budget = n * 6 + 30;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'(base);
    length = 11'(len);
    out_ready = 1'b1;
    #2;
    chk("idle_busy", busy, 0);
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (mid && c == 2) begin
        start = 1'b1;
        base_addr = 10'd700;
        length = 11'd3;
      end
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ((c - 1) % 3 == 0);
        default: out_ready = ($urandom % 4) != 0;
      endcase
      #2;
      if (c == 1) chk("busy_run", busy, 1);
      if (mem_r_en) begin
        if (first_en < 0) first_en = c;
        chk("addr", mem_r_addr, (base + issued) % 1024);
        issued++;
      end
      if (out_valid) begin
        if (first_val < 0) first_val = c;
        if (held) chk("stall_stable", out_data, held_d);
        chk("data", out_data, word_at(base + popped));
        chk("last", out_last, popped == n - 1);
      end
      held = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        popped++;
        last_pop_c = c;
      end
      chk("in_flight_le2", (issued - popped) <= 2, 1);
      if (done) begin
        done_c = c;
        break;
      end
    end
    chk("done_seen", done_c > 0, 1);
    chk("beats", popped, n);
    chk("reads", issued, n);
    if (n > 0) begin
      chk("done_cycle", done_c, last_pop_c + 1);
    end else begin
      chk("done_cycle_empty", done_c, 2);
      chk("no_valid_empty", first_val, -1);
    end
    if (timing) begin
      chk("first_en", first_en, 1);
      chk("first_valid", first_val, 3);
    end
    chk_stats(base, n);
    @(posedge clk);
    #3;
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("valid_after", out_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i - 512);

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", mem_r_en, 0);
    chk("rst_addr", mem_r_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_smin", stat_min, 0);
    chk("rst_smax", stat_max, 0);
    chk("rst_ssum", stat_sum, 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // basic job with a start pulse mid-job
    run_job(0, 4, 0, 1'b1, 1'b1);
    // address wrap
    run_job(1022, 4, 0, 1'b0, 1'b1);
    // backpressure
    run_job(100, 8, 1, 1'b0, 1'b1);
    // empty job
    run_job(5, 0, 0, 1'b0, 1'b0);

    // reset during the second beat of a 16-word job
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'd0;
    length = 11'd16;
    out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    #2;
    chk("pre_rst_beat2", out_data, -511);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_en", mem_r_en, 0);
    chk("mid_rst_addr", mem_r_addr, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #3;
      if (done || out_valid || busy || mem_r_en)
        chk("post_rst_quiet", 1, 0);
    end
    chk("post_rst_idle", busy, 0);
    run_job(0, 4, 0, 1'b0, 1'b1);

    // stats job; values must hold after done
    run_job(500, 20, 0, 1'b0, 1'b1);
`ifdef MEMORY_LIST_STREAMER_STATS_EN
    chk("hold_min", stat_min, -12);
    chk("hold_max", stat_max, 7);
    chk("hold_sum", stat_sum, -50);
`else
    chk("hold_min", stat_min, 0);
    chk("hold_max", stat_max, 0);
    chk("hold_sum", stat_sum, 0);
`endif

    // length above depth clamps to a full sweep
    run_job(300, 1500, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_job(int'($urandom % 1024),
              int'($urandom_range(1, 40)), 2, 1'b0, 1'b0);
    end
    run_job(int'($urandom % 1024), 12, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
